// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives a req/ack data-memory port, stalls upstream while an access
// is outstanding, and holds the MEM/WB register. Flags misaligned and timed-out accesses.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteIn,
  input  logic        memReadIn,
  input  logic        memToRegIn,
  input  logic        regWriteIn,
  input  logic [31:0] aluIn,
  input  logic [31:0] rd2In,
  input  logic [4:0]  wnIn,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic [31:0] rdOut,
  output logic [31:0] aluOut,
  output logic [4:0]  wnOut,
  output logic        memErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc, mis, inAccess, lastCycle;

  assign acc       = memReadIn | memWriteIn;
  assign mis       = acc & (aluIn[1:0] != 2'b00);
  assign inAccess  = !rst && (state == ACCESS);
  assign lastCycle = (cnt == CW'(TIMEOUT - 1));

  // Memory port is live only in ACCESS; EX/MEM is frozen by stall so it stays stable.
  assign memReq   = inAccess;
  assign memWe    = inAccess & memWriteIn;
  assign memAddr  = inAccess ? aluIn : 32'h0;
  assign memWdata = inAccess ? rd2In : 32'h0;
  assign stall    = !rst && (((state == IDLE) && acc && !mis) ||
                             ((state == ACCESS) && !memAck && !lastCycle));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      regWriteOut <= 1'b0;
      memToRegOut <= 1'b0;
      rdOut       <= 32'h0;
      aluOut      <= 32'h0;
      wnOut       <= 5'd0;
      memErr      <= 1'b0;
    end else begin
      // Default: bubble into MEM/WB; overridden when an instruction retires this edge.
      regWriteOut <= 1'b0;
      memToRegOut <= 1'b0;
      rdOut       <= 32'h0;
      aluOut      <= 32'h0;
      wnOut       <= 5'd0;
      case (state)
        IDLE: begin
          if (!acc) begin
            regWriteOut <= regWriteIn;
            memToRegOut <= memToRegIn;
            aluOut      <= aluIn;
            wnOut       <= wnIn;
          end else if (mis) begin
            memErr <= 1'b1;
          end else begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (memAck) begin
            regWriteOut <= regWriteIn;
            memToRegOut <= memToRegIn;
            aluOut      <= aluIn;
            wnOut       <= wnIn;
            // A combined read+write is a store, so no load data comes back.
            rdOut       <= (memReadIn && !memWriteIn) ? memRdata : 32'h0;
            state       <= IDLE;
          end else if (lastCycle) begin
            memErr <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl; each instruction's expected cycle schedule and
// MEM/WB result are computed from the stage rules at transaction level.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memWriteIn, memReadIn, memToRegIn, regWriteIn;
  logic [31:0] aluIn, rd2In;
  logic [4:0]  wnIn;
  logic        stall, memReq, memWe;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memAck;
  logic        regWriteOut, memToRegOut;
  logic [31:0] rdOut, aluOut;
  logic [4:0]  wnOut;
  logic        memErr;

  int nCmp = 0;
  int nErr = 0;
  logic errModel = 1'b0;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memWriteIn(memWriteIn), .memReadIn(memReadIn), .memToRegIn(memToRegIn),
    .regWriteIn(regWriteIn), .aluIn(aluIn), .rd2In(rd2In), .wnIn(wnIn),
    .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck),
    .regWriteOut(regWriteOut), .memToRegOut(memToRegOut), .rdOut(rdOut),
    .aluOut(aluOut), .wnOut(wnOut), .memErr(memErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkWb(input logic rw, input logic m2r, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wn);
    chk("regWriteOut", {31'b0, regWriteOut}, {31'b0, rw});
    chk("memToRegOut", {31'b0, memToRegOut}, {31'b0, m2r});
    chk("rdOut", rdOut, rd);
    chk("aluOut", aluOut, alu);
    chk("wnOut", {27'b0, wnOut}, {27'b0, wn});
    chk("memErr", {31'b0, memErr}, {31'b0, errModel});
  endtask

  task automatic chkIdlePort(input logic expStall);
    chk("stallIdle", {31'b0, stall}, {31'b0, expStall});
    chk("memReqIdle", {31'b0, memReq}, 32'h0);
    chk("memAddrIdle", memAddr, 32'h0);
    chk("memWeIdle", {31'b0, memWe}, 32'h0);
  endtask

  // Called at posedge+1. ackLat = ACCESS cycle carrying memAck (values above TO time out).
  task automatic runInstr(input logic mw, input logic mr, input logic m2r, input logic rw,
                          input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn,
                          input int ackLat, input logic [31:0] rdata);
    logic acc, mis;
    acc = mw | mr;
    mis = acc && (alu[1:0] != 2'b00);
    memWriteIn = mw; memReadIn = mr; memToRegIn = m2r; regWriteIn = rw;
    aluIn = alu; rd2In = rd2; wnIn = wn;
    memAck = 1'($urandom_range(0, 1));
    memRdata = $urandom;
    if (!acc || mis) begin
      @(negedge clk);
      chkIdlePort(1'b0);
      @(posedge clk); #1;
      memAck = 1'b0;
      if (mis) begin
        errModel = 1'b1;
        chkWb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      end else begin
        chkWb(rw, m2r, 32'h0, alu, wn);
      end
    end else begin
      @(negedge clk);
      chkIdlePort(1'b1);
      @(posedge clk); #1;
      for (int c = 1; c <= TO; c++) begin
        memAck = (c == ackLat);
        memRdata = (c == ackLat) ? rdata : $urandom;
        @(negedge clk);
        chk("memReq", {31'b0, memReq}, 32'h1);
        chk("memWe", {31'b0, memWe}, {31'b0, mw});
        chk("memAddr", memAddr, alu);
        chk("memWdata", memWdata, rd2);
        chk("stallAcc", {31'b0, stall}, {31'b0, (c != ackLat) && (c != TO)});
        @(posedge clk); #1;
        if (c == ackLat) break;
      end
      memAck = 1'b0;
      if (ackLat > TO) begin
        errModel = 1'b1;
        chkWb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      end else begin
        chkWb(rw, m2r, (mr && !mw) ? rdata : 32'h0, alu, wn);
      end
    end
  endtask

  initial begin
    logic [31:0] r, a;
    int kind;
    rst = 1'b1; memAck = 1'b1; memReadIn = 1'b1; memWriteIn = 1'b0;
    memToRegIn = 1'b0; regWriteIn = 1'b0; aluIn = 32'h0; rd2In = 32'h0;
    wnIn = 5'd0; memRdata = 32'h0;
    // Reset with a pending load and a spurious ack
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstStall", {31'b0, stall}, 32'h0);
    chk("rstReq", {31'b0, memReq}, 32'h0);
    @(posedge clk); #1;
    chkWb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst = 1'b0; memAck = 1'b0; memReadIn = 1'b0;

    runInstr(0, 0, 0, 1, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    runInstr(0, 1, 1, 1, 32'h100, 32'h0, 5'd8, 3, 32'hDEADBEEF);
    runInstr(1, 0, 0, 0, 32'h200, 32'hCAFE, 5'd0, 1, 32'h0);
    runInstr(0, 1, 1, 1, 32'h300, 32'h0, 5'd9, TO + 1, 32'h0);
    runInstr(0, 0, 0, 1, 32'h77, 32'h0, 5'd3, 0, 32'h0);
    runInstr(1, 1, 1, 1, 32'h40, 32'h55, 5'd4, 2, 32'h12345678);
    runInstr(0, 1, 1, 1, 32'h102, 32'h0, 5'd8, 1, 32'h0);

    // Reset in the middle of an access
    memReadIn = 1'b1; regWriteIn = 1'b1; memToRegIn = 1'b1; aluIn = 32'h400; wnIn = 5'd7;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midReqBefore", {31'b0, memReq}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midRstReq", {31'b0, memReq}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; memReadIn = 1'b0; regWriteIn = 1'b0; memToRegIn = 1'b0;
    errModel = 1'b0;
    chkWb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    chkIdlePort(1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      a = $urandom;
      if ((r % 6) != 0) a[1:0] = 2'b00;
      kind = int'(r[7:4] % 4);
      case (kind)
        0: runInstr(0, 0, 0, r[8], a, $urandom, 5'(r[20:16]), 0, 32'h0);
        1: runInstr(0, 1, 1, 1, a, $urandom, 5'(r[20:16]),
                    $urandom_range(1, TO + 1), $urandom);
        2: runInstr(1, 0, 0, 0, a, $urandom, 5'(r[20:16]),
                    $urandom_range(1, TO + 1), $urandom);
        default: runInstr(1, 1, r[9], r[8], a, $urandom, 5'(r[20:16]),
                          $urandom_range(1, TO + 1), $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
